// File: rtl/prio_encoder_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_rr_if
// Brief    : Request / result handshake bundle for prio_encoder_rr.
// Revision : 1.0
// ============================================================================
interface prio_encoder_rr_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic         En;
    logic [N-1:0] Din;
    logic         Dr;
    logic [W-1:0] Do;
    logic         Dv;
    logic         Derr;

    modport master (
        output En, Din, Dr,
        input  Do, Dv, Derr
    );

    modport slave (
        input  En, Din, Dr,
        output Do, Dv, Derr
    );
endinterface
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module   : prio_encoder_rr
// Brief    : Registered fixed / round-robin priority encoder with valid/ready.
// Revision : 1.0
// ============================================================================
module prio_encoder_rr #(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    prio_encoder_rr_if.slave    bus
);
    localparam logic [0:0]   S_IDLE = 1'b0;
    localparam logic [0:0]   S_HOLD = 1'b1;
    localparam int unsigned  WI     = W + 1;
    localparam logic [N-1:0] ONE    = 1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic         derr_q, derr_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         sel_found;
    logic [W-1:0] sel_idx;
    logic [W:0]   cand;
    logic         multi;
    logic         capture;
    logic [W-1:0] ptr_inc;

    // Scan upward from ptr with wrap; in fixed mode ptr is pinned at zero.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + WI'(i);
            if (cand >= WI'(N)) begin
                cand = cand - WI'(N);
            end
            if (!sel_found && bus.Din[cand[W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[W-1:0];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi   = |(bus.Din & (bus.Din - ONE));
    assign capture = bus.En && sel_found && ((state_q == S_IDLE) || bus.Dr);

    generate
        if (RR != 0) begin : g_rr
            assign ptr_inc = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
        end else begin : g_fixed
            assign ptr_inc = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        derr_d  = derr_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.Dr && !capture) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            idx_d  = sel_idx;
            derr_d = multi;
            ptr_d  = ptr_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            derr_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            derr_q  <= derr_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.Do   = idx_q;
    assign bus.Dv   = (state_q == S_HOLD);
    assign bus.Derr = derr_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_encoder_rr
// Brief    : Directed and random checks of three prio_encoder_rr configurations.
// Revision : 1.0
// ============================================================================
module tb_prio_encoder_rr;
    localparam int NK  [3] = '{4, 8, 4};
    localparam bit RRK [3] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en   [3];
    logic [7:0] din  [3];
    logic       dr   [3];
    logic [7:0] o_do [3];
    logic       o_dv [3];
    logic       o_derr [3];

    int m_do [3];
    bit m_dv [3];
    bit m_derr [3];
    int m_ptr [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prio_encoder_rr_if #(.N(4)) ifa ();
    prio_encoder_rr_if #(.N(8)) ifb ();
    prio_encoder_rr_if #(.N(4)) ifc ();

    prio_encoder_rr #(.N(4), .RR(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    prio_encoder_rr #(.N(8), .RR(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    prio_encoder_rr #(.N(4), .RR(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.En = en[0]; assign ifa.Din = din[0][3:0]; assign ifa.Dr = dr[0];
    assign ifb.En = en[1]; assign ifb.Din = din[1];      assign ifb.Dr = dr[1];
    assign ifc.En = en[2]; assign ifc.Din = din[2][3:0]; assign ifc.Dr = dr[2];
    assign o_do[0] = 8'(ifa.Do); assign o_dv[0] = ifa.Dv; assign o_derr[0] = ifa.Derr;
    assign o_do[1] = 8'(ifb.Do); assign o_dv[1] = ifb.Dv; assign o_derr[1] = ifb.Derr;
    assign o_do[2] = 8'(ifc.Do); assign o_dv[2] = ifc.Dv; assign o_derr[2] = ifc.Derr;

    // First pending request at or above base, wrapping at n; -1 when none.
    function automatic int pick(logic [7:0] d, int n, int base);
        for (int j = 0; j < n; j++) begin
            int idx = (base + j) % n;
            if (d[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_do[k] <= 0; m_dv[k] <= 1'b0; m_derr[k] <= 1'b0; m_ptr[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (en[k] && (!m_dv[k] || dr[k]) && pick(din[k], NK[k], m_ptr[k]) >= 0) begin
                    m_do[k]   <= pick(din[k], NK[k], m_ptr[k]);
                    m_dv[k]   <= 1'b1;
                    m_derr[k] <= ($countones(din[k]) > 1);
                    if (RRK[k]) m_ptr[k] <= (pick(din[k], NK[k], m_ptr[k]) + 1) % NK[k];
                end else if (m_dv[k] && dr[k]) begin
                    m_dv[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model[%0d].Do", k),   32'(o_do[k]),   32'(m_do[k][7:0]));
            chk($sformatf("model[%0d].Dv", k),   32'(o_dv[k]),   32'(m_dv[k]));
            chk($sformatf("model[%0d].Derr", k), 32'(o_derr[k]), 32'(m_derr[k]));
        end
    endtask

    task automatic set_all(input logic e, input logic [7:0] d, input logic r);
        for (int k = 0; k < 3; k++) begin
            en[k] = e; din[k] = d; dr[k] = r;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s[%0d].Do", tag, k),   32'(o_do[k]),   32'd0);
            chk($sformatf("%s[%0d].Dv", tag, k),   32'(o_dv[k]),   32'd0);
            chk($sformatf("%s[%0d].Derr", tag, k), 32'(o_derr[k]), 32'd0);
        end
    endtask

    initial begin
        set_all(1'b0, 8'h00, 1'b0);
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle: no requests, nothing becomes valid.
        set_all(1'b1, 8'h00, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) chk($sformatf("idle[%0d].Dv", k), 32'(o_dv[k]), 32'd0);

        // Fixed one-hot on the 4-bit fixed instance.
        for (int i = 0; i < 4; i++) begin
            din[0] = 8'(1 << i);
            tick();
            chk("onehot.Do", 32'(o_do[0]), 32'(i));
            chk("onehot.Dv", 32'(o_dv[0]), 32'd1);
            chk("onehot.Derr", 32'(o_derr[0]), 32'd0);
        end

        // Fixed multi-hot on the 8-bit instance.
        din[1] = 8'b1010_0100;
        tick();
        chk("multihot.Do", 32'(o_do[1]), 32'd2);
        chk("multihot.Derr", 32'(o_derr[1]), 32'd1);

        // Round-robin fairness, then wrap from index 3.
        din[2] = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr.Do", 32'(o_do[2]), 32'(i % 4));
        end
        din[2] = 8'h08;
        tick();
        chk("rr.wrap.Do", 32'(o_do[2]), 32'd3);
        din[2] = 8'h0F;
        tick();
        chk("rr.after_wrap.Do", 32'(o_do[2]), 32'd0);

        // Backpressure on the 4-bit fixed instance.
        din[0] = 8'h04; dr[0] = 1'b1;
        tick();
        chk("bp.capture.Do", 32'(o_do[0]), 32'd2);
        din[0] = 8'h01; dr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.hold.Do", 32'(o_do[0]), 32'd2);
            chk("bp.hold.Dv", 32'(o_dv[0]), 32'd1);
        end
        dr[0] = 1'b1;
        tick();
        chk("bp.release.Do", 32'(o_do[0]), 32'd0);
        chk("bp.release.Dv", 32'(o_dv[0]), 32'd1);
        en[0] = 1'b0;
        tick();
        chk("bp.drain.Dv", 32'(o_dv[0]), 32'd0);

        // Reset while holding Do=3 in round-robin mode.
        din[2] = 8'h08; dr[2] = 1'b1; en[2] = 1'b1;
        tick();
        chk("rsthold.Do", 32'(o_do[2]), 32'd3);
        dr[2] = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk_zero("rsthold");
        @(negedge clk);
        rst = 1'b0;

        // A non-zero pointer must also be cleared by reset.
        set_all(1'b0, 8'h00, 1'b0);
        din[2] = 8'h02; en[2] = 1'b1; dr[2] = 1'b1;
        tick();
        dr[2] = 1'b0; en[2] = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rstptr.Dv", 32'(o_dv[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        din[2] = 8'h06; en[2] = 1'b1; dr[2] = 1'b1;
        tick();
        chk("rstptr.Do", 32'(o_do[2]), 32'd1);

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                en[k]  = ($urandom_range(0, 3) != 0);
                din[k] = ($urandom_range(0, 4) == 0) ? 8'h00
                         : 8'($urandom & ((1 << NK[k]) - 1));
                dr[k]  = ($urandom_range(0, 9) < 6);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered priority encoder with an output valid/ready handshake. It is the successor to the combinational 4-to-2 one-hot encoder. It converts an N-bit request vector into a binary index, with either fixed (LSB-first) or round-robin priority, and holds each result until downstream accepts it. Outputs are never tri-stated: "no request" is signalled by Dv low. The block sits between request sources (interrupt lines, channel requests) and a single consumer that needs one index at a time.

## Interface
- N, 8, number of request lines; legal range 2..64.
- W, $clog2(N), width of the index output; derived, do not override.
- RR, 0, priority mode: 0 = fixed, lowest index wins; 1 = round-robin.
- clk  in  1  rising-edge clock; the block has a single clock domain.
- rst  in  1  asynchronous, active-high reset.
- En  in  1  capture enable; when low, no new capture occurs.
- Din  in  N  request vector; bit i set means request i is pending.
- Dr  in  1  downstream ready; a transfer occurs on a cycle where Dv=1 and Dr=1.
- Do  out  W  registered index of the selected request.
- Dv  out  1  Do holds an unaccepted result.
- Derr  out  1  more than one Din bit was set at capture; qualified by Dv.

## Operation
- Reset values while rst=1: Do=0, Dv=0, Derr=0, state=IDLE, round-robin pointer ptr=0.
- Select function, evaluated on the Din value present at the capturing edge:
  - RR=0: lowest set bit of Din.
  - RR=1: first set bit at or above ptr, wrapping from N-1 to 0.
  - Din=0 produces no selection.
- A capture occurs when En=1, Din!=0, and the state is either IDLE, or HOLD with Dr=1 in the same cycle.
- On capture:
  - Do ← selected index.
  - Dv ← 1.
  - Derr ← (popcount(Din) > 1).
  - If RR=1: ptr ← (index+1) mod N. When index = N-1, ptr wraps to 0.
- State IDLE, Dv=0:
  - Capture → HOLD.
  - Otherwise stay in IDLE; Do and Derr retain their last values.
- State HOLD, Dv=1:
  - Do and Derr must stay stable until transfer.
  - Dr=0: stay in HOLD; Din and En are ignored.
  - Dr=1 with a capture: stay in HOLD and load the new result (back-to-back).
  - Dr=1 without a capture (En=0 or Din=0): → IDLE, Dv ← 0.
- En=0 does not abort a held result; it still completes on Dr.
- Din is sampled only at capture edges. A request that deasserts before a capture edge is lost; the block does not latch requests.
- In RR=1 mode, ptr changes only on capture, never on transfer alone.
- An asynchronous rst while in HOLD discards the held result: Dv drops in the same cycle, with no transfer.

## Timing
- Latency: Din at edge k gives Do/Dv valid after edge k (one cycle).
- Throughput: one result per cycle when Dr is held high and requests are present.
- Dv=1 is guaranteed to stay high until the transfer cycle; Do must not change while Dv=1 and Dr=0.
- Dr is allowed to be high while Dv=0; it has no effect in that case.
- All outputs are driven only by flops; there is no combinational path from Din or Dr to any output.
- Reset:
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Release is synchronised by the user.
  - The first capture is possible on the first rising edge after rst falls.

## Test plan
- Reset, then check idle behaviour:
  - Assert rst mid-simulation → Do=0, Dv=0, Derr=0 immediately, before the next edge.
  - With Din=0 and En=1 → Dv stays 0.
- Fixed one-hot, N=4, RR=0, Dr=1, En=1: Din=0001, 0010, 0100, 1000 on successive cycles → Do=0, 1, 2, 3 one cycle later each, Dv=1 throughout, Derr=0.
- Fixed multi-hot, N=8, RR=0: Din=8'b1010_0100 → Do=2, Derr=1.
- Round-robin fairness, N=4, RR=1: hold Din=1111, Dr=1 for 6 cycles → Do sequence 0,1,2,3,0,1. Then Din=1000 → Do=3, ptr wraps to 0.
- Backpressure:
  - Capture Din=0100, then hold Dr=0 for 3 cycles while Din=0001 → Do=2 and Dv=1 remain stable.
  - Raise Dr with Din=0001 → next Do=0.
  - Then drop En with Dr=1 → Dv=0 on the following cycle.
- Reset mid-hold: while in HOLD with Do=3 and Dr=0, pulse rst between edges → Dv falls asynchronously, and ptr returns to 0 in RR=1 mode.
